// File: rtl/nav_pkg.sv
// nav_pkg: shared encodings, one-hot selects and state type for the navigation command sequencer
package nav_pkg;
    localparam logic [1:0] OP_ZERO    = 2'b00;
    localparam logic [1:0] OP_CRUISE  = 2'b01;
    localparam logic [1:0] OP_JUMP    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] SPD_NONE    = 2'b00;
    localparam logic [1:0] SPD_ATTACK  = 2'b01;
    localparam logic [1:0] SPD_DEFENSE = 2'b10;
    localparam logic [1:0] SPD_STEALTH = 2'b11;

    localparam logic [3:0] MODE_ZERO    = 4'b0001;
    localparam logic [3:0] MODE_ATTACK  = 4'b0010;
    localparam logic [3:0] MODE_DEFENSE = 4'b0100;
    localparam logic [3:0] MODE_STEALTH = 4'b1000;

    localparam logic [3:0] POS_ZERO     = 4'b0001;
    localparam logic [3:0] POS_SUBLIGHT = 4'b0010;
    localparam logic [3:0] POS_JUMP     = 4'b0100;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORT   = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {S_ZERO, S_IDLE, S_CRUISE, S_JUMP} state_e;

    function automatic logic [3:0] speed_mode(input logic [1:0] s);
        return s == SPD_ATTACK  ? MODE_ATTACK  :
               s == SPD_DEFENSE ? MODE_DEFENSE :
               s == SPD_STEALTH ? MODE_STEALTH : MODE_ZERO;
    endfunction
endpackage

// File: rtl/nav_shadow_integrator.sv
// nav_shadow_integrator: mirror of the axis position register (zero/add/load/hold from the one-hot selects)
module nav_shadow_integrator
    import nav_pkg::*;
#(
    parameter int K             = 16,
    parameter int ATTACK_SPEED  = 1,
    parameter int DEFENSE_SPEED = 1,
    parameter int STEALTH_SPEED = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   mode,
    input  logic [3:0]   pos_mode,
    input  logic [K-1:0] jump_position,
    output logic [K-1:0] est
);
    logic [K-1:0] vel;
    logic [K-1:0] est_d;

    always_comb begin
        vel   = mode == MODE_ATTACK  ? K'(ATTACK_SPEED)  :
                mode == MODE_DEFENSE ? K'(DEFENSE_SPEED) :
                mode == MODE_STEALTH ? K'(STEALTH_SPEED) : '0;
        est_d = pos_mode == POS_ZERO     ? '0            :
                pos_mode == POS_SUBLIGHT ? est + vel     :
                pos_mode == POS_JUMP     ? jump_position : est;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) est <= '0;
        else        est <= est_d;
endmodule

// File: rtl/nav_command_sequencer.sv
// nav_command_sequencer: accepts navigation commands and drives the integrator's one-hot selects
module nav_command_sequencer
    import nav_pkg::*;
#(
    parameter int K             = 16,
    parameter int CNT_W         = 8,
    parameter int ATTACK_SPEED  = 1,
    parameter int DEFENSE_SPEED = 1,
    parameter int STEALTH_SPEED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_speed,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [K-1:0]     cmd_jump_pos,
    input  logic             abort,
    output logic [3:0]       mode,
    output logic [3:0]       pos_mode,
    output logic [K-1:0]     jump_position,
    output logic             done,
    output logic [1:0]       status,
    output logic [K-1:0]     est_position
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       speed_q, speed_d;
    logic [K-1:0]     jump_q, jump_d;
    logic             done_d;
    logic [1:0]       status_d;
    logic             boot_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= S_ZERO;
            cnt_q   <= '0;
            speed_q <= SPD_NONE;
            jump_q  <= '0;
            done    <= 1'b0;
            status  <= ST_OK;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
            jump_q  <= jump_d;
            done    <= done_d;
            status  <= status_d;
            boot_q  <= 1'b0;
        end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        speed_d  = speed_q;
        jump_d   = jump_q;
        done_d   = 1'b0;
        status_d = ST_OK;
        case (state_q)
            S_ZERO: begin
                state_d = S_IDLE;
                done_d  = !boot_q;
            end
            S_IDLE:
                if (cmd_valid)
                    case (cmd_op)
                        OP_ZERO: state_d = S_ZERO;
                        OP_CRUISE: begin
                            speed_d = cmd_speed;
                            cnt_d   = cmd_count;
                            state_d = cmd_count == '0 ? S_IDLE : S_CRUISE;
                            done_d  = cmd_count == '0;
                        end
                        OP_JUMP: begin
                            jump_d  = cmd_jump_pos;
                            state_d = S_JUMP;
                        end
                        default: begin
                            done_d   = 1'b1;
                            status_d = ST_ILLEGAL;
                        end
                    endcase
            S_CRUISE: begin
                cnt_d = cnt_q - CNT_W'(1);
                // abort still lets this cycle's step complete; it only cuts the remaining count
                if (abort || cnt_q == CNT_W'(1)) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    status_d = abort ? ST_ABORT : ST_OK;
                end
            end
            S_JUMP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    assign cmd_ready     = state_q == S_IDLE;
    assign mode          = state_q == S_CRUISE ? speed_mode(speed_q) : MODE_ZERO;
    assign pos_mode      = state_q == S_ZERO ? POS_ZERO : state_q == S_JUMP ? POS_JUMP : POS_SUBLIGHT;
    assign jump_position = jump_q;

    nav_shadow_integrator #(
        .K(K), .ATTACK_SPEED(ATTACK_SPEED), .DEFENSE_SPEED(DEFENSE_SPEED), .STEALTH_SPEED(STEALTH_SPEED)
    ) u_shadow (
        .clk(clk),
        .rst_n(rst_n),
        .mode(mode),
        .pos_mode(pos_mode),
        .jump_position(jump_position),
        .est(est_position)
    );
endmodule

// File: tb/tb_nav_command_sequencer.sv
// tb_nav_command_sequencer: directed checks of the command sequencer with hand-computed expectations
module tb_nav_command_sequencer;
    localparam int K = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_speed;
    logic [CNT_W-1:0] cmd_count;
    logic [K-1:0]     cmd_jump_pos;
    logic             abort;
    logic [3:0]       mode;
    logic [3:0]       pos_mode;
    logic [K-1:0]     jump_position;
    logic             done;
    logic [1:0]       status;
    logic [K-1:0]     est_position;

    int total = 0;
    int passed = 0;
    int fails = 0;

    nav_command_sequencer #(
        .K(K), .CNT_W(CNT_W), .ATTACK_SPEED(3), .DEFENSE_SPEED(1), .STEALTH_SPEED(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_speed(cmd_speed),
        .cmd_count(cmd_count),
        .cmd_jump_pos(cmd_jump_pos),
        .abort(abort),
        .mode(mode),
        .pos_mode(pos_mode),
        .jump_position(jump_position),
        .done(done),
        .status(status),
        .est_position(est_position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag, input logic exp_done, input logic [1:0] exp_status,
                            input logic [K-1:0] exp_est);
        chk({tag, " done"}, 32'(done), 32'(exp_done));
        if (exp_done) chk({tag, " status"}, 32'(status), 32'(exp_status));
        chk({tag, " mode"}, 32'(mode), 32'h1);
        chk({tag, " pos_mode"}, 32'(pos_mode), 32'h2);
        chk({tag, " ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, " est"}, 32'(est_position), 32'(exp_est));
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] spd, input logic [CNT_W-1:0] cnt,
                         input logic [K-1:0] jp);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_speed = spd;
        cmd_count = cnt;
        cmd_jump_pos = jp;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_speed = 2'b00;
        cmd_count = '0;
        cmd_jump_pos = '0;
        abort = 1'b0;
        #3;
        chk("rst mode", 32'(mode), 32'h1);
        chk("rst pos_mode", 32'(pos_mode), 32'h1);
        chk("rst ready", 32'(cmd_ready), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst est", 32'(est_position), 32'h0);
        chk("rst jump", 32'(jump_position), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        chk("post-rst zero pos_mode", 32'(pos_mode), 32'h1);
        chk("post-rst zero ready", 32'(cmd_ready), 32'h0);
        tick();
        idle_chk("boot idle", 1'b0, 2'b00, 16'h0);
        tick();
        chk("boot idle2 done", 32'(done), 32'h0);

        // CRUISE attack x5, step 3
        issue(2'b01, 2'b01, 8'd5, 16'h0);
        for (int i = 0; i < 5; i++) begin
            chk("atk mode", 32'(mode), 32'h2);
            chk("atk pos_mode", 32'(pos_mode), 32'h2);
            chk("atk est", 32'(est_position), 32'(3 * i));
            chk("atk done", 32'(done), 32'h0);
            tick();
        end
        idle_chk("atk end", 1'b1, 2'b00, 16'd15);

        // JUMP 0x0249 accepted in the done cycle, then stealth x2 in its done cycle
        issue(2'b10, 2'b00, 8'd0, 16'h0249);
        chk("jmp pos_mode", 32'(pos_mode), 32'h4);
        chk("jmp target", 32'(jump_position), 32'h0249);
        chk("jmp est", 32'(est_position), 32'd15);
        chk("jmp ready", 32'(cmd_ready), 32'h0);
        tick();
        idle_chk("jmp end", 1'b1, 2'b00, 16'h0249);
        issue(2'b01, 2'b11, 8'd2, 16'h0);
        chk("stl mode", 32'(mode), 32'h8);
        chk("stl est0", 32'(est_position), 32'h0249);
        chk("jump hold", 32'(jump_position), 32'h0249);
        tick();
        chk("stl est1", 32'(est_position), 32'h024A);
        tick();
        idle_chk("stl end", 1'b1, 2'b00, 16'h024B);

        // wrap-around through 0xFFFF
        issue(2'b10, 2'b00, 8'd0, 16'hFFFE);
        tick();
        idle_chk("jmp2 end", 1'b1, 2'b00, 16'hFFFE);
        issue(2'b01, 2'b10, 8'd3, 16'h0);
        chk("def mode", 32'(mode), 32'h4);
        chk("def est0", 32'(est_position), 32'hFFFE);
        tick();
        chk("def est1", 32'(est_position), 32'hFFFF);
        tick();
        chk("def est2", 32'(est_position), 32'h0000);
        tick();
        idle_chk("def end", 1'b1, 2'b00, 16'h0001);

        // long attack cruise aborted on its 4th cycle
        issue(2'b01, 2'b01, 8'd200, 16'h0);
        repeat (3) tick();
        chk("abt 4th mode", 32'(mode), 32'h2);
        chk("abt 4th est", 32'(est_position), 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_chk("abt end", 1'b1, 2'b01, 16'd13);

        // zero-length cruise, then illegal op with abort asserted alongside
        issue(2'b01, 2'b01, 8'd0, 16'h0);
        idle_chk("cnt0", 1'b1, 2'b00, 16'd13);
        abort = 1'b1;
        issue(2'b11, 2'b00, 8'd0, 16'h0);
        abort = 1'b0;
        idle_chk("illegal", 1'b1, 2'b10, 16'd13);
        tick();
        chk("illegal pulse", 32'(done), 32'h0);

        // ZERO op: one zero cycle then done in IDLE
        issue(2'b00, 2'b00, 8'd0, 16'h0);
        chk("zero pos_mode", 32'(pos_mode), 32'h1);
        chk("zero ready", 32'(cmd_ready), 32'h0);
        chk("zero done", 32'(done), 32'h0);
        tick();
        idle_chk("zero end", 1'b1, 2'b00, 16'h0);

        // asynchronous reset mid-cruise
        issue(2'b01, 2'b01, 8'd10, 16'h0);
        tick();
        chk("pre-rst est", 32'(est_position), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst mode", 32'(mode), 32'h1);
        chk("arst pos_mode", 32'(pos_mode), 32'h1);
        chk("arst est", 32'(est_position), 32'h0);
        chk("arst jump", 32'(jump_position), 32'h0);
        chk("arst ready", 32'(cmd_ready), 32'h0);
        chk("arst done", 32'(done), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        idle_chk("arst idle", 1'b0, 2'b00, 16'h0);
        tick();
        chk("arst no done", 32'(done), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nav_command_sequencer.md
Name: nav_command_sequencer

Overview:
- Command-side initiator for the axis position integrator (Axis_Position). Accepts navigation commands over a valid/ready handshake and emits, cycle by cycle, the one-hot `mode` (velocity select) and one-hot `pos_mode` (next-position select) plus `jump_position`.
- Keeps a shadow copy of the integrated position, so the controller and the bench can check the integrator without probing it hierarchically.
- One instance per axis, sitting between flight control and the integrator.

Parameters:
- K, 16, position/velocity width; must match the integrator.
- CNT_W, 8, width of the cruise cycle-count field.
- ATTACK_SPEED, 1, per-cycle step for attack velocity; must match the integrator.
- DEFENSE_SPEED, 1, per-cycle step for defense velocity; must match the integrator.
- STEALTH_SPEED, 1, per-cycle step for stealth velocity; must match the integrator.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  00 ZERO, 01 CRUISE, 10 JUMP, 11 reserved.
- cmd_speed  in  2  CRUISE velocity: 00 none, 01 attack, 10 defense, 11 stealth.
- cmd_count  in  CNT_W  CRUISE duration in cycles.
- cmd_jump_pos  in  K  JUMP target.
- abort  in  1  ends an in-progress CRUISE.
- mode  out  4  one-hot velocity select: 0001 zero, 0010 attack, 0100 defense, 1000 stealth.
- pos_mode  out  4  one-hot position select: 0001 zero, 0010 sublight (pos+vel), 0100 jump; 1000 is never driven.
- jump_position  out  K  jump target presented to the integrator.
- done  out  1  one-cycle pulse on command completion.
- status  out  2  valid with done: 00 ok, 01 aborted, 10 illegal op.
- est_position  out  K  shadow position, equal to the integrator's register each cycle.

Behaviour:
- Moore outputs, decoded only from registered state. No combinational path from any input to any output.
- States: ZERO, IDLE, CRUISE, JUMP.
- Reset (rst_n low, asynchronous):
  - state=ZERO; mode=0001; pos_mode=0001; jump_position=0; est_position=0; done=0; status=00; cmd_ready=0; internal counter=0.
  - After release, one more ZERO cycle, then IDLE.
- ZERO: mode=0001, pos_mode=0001. Next est=0. Next state IDLE. done=1 with status=00 on the following IDLE cycle, except for the post-reset pass, where done stays 0.
- IDLE (hold): mode=0001, pos_mode=0010, so the integrator adds zero. est unchanged. cmd_ready=1.
- Accept on cmd_valid&&cmd_ready at edge t. The op state is active from cycle t+1. Command fields are captured into registers at acceptance.
- CRUISE, cmd_count=N≥1:
  - Exactly N cycles with mode=speed one-hot and pos_mode=0010. est += speed each cycle.
  - Then IDLE with done=1, status=00.
  - N=0: remains in IDLE; done=1 on cycle t+1; no motion.
- cmd_speed=00 in CRUISE: mode=0001, zero step; counts normally.
- JUMP: one cycle with pos_mode=0100, jump_position=target. Next est=target. Then IDLE with done=1.
- jump_position holds its last target outside JUMP.
- Illegal op 11: no motion; stays in IDLE; done=1, status=10 on t+1.
- abort during CRUISE: the current cycle's step still completes. Next cycle is IDLE with done=1, status=01.
- abort in any other state is ignored.
- abort in the same cycle a command is accepted is ignored.
- done in IDLE and a new acceptance may coincide; back-to-back commands have no idle gap beyond the done cycle.
- est arithmetic is modulo 2^K. Wrap-around is silent, with no saturation or flag.
- Asynchronous reset mid-CRUISE or mid-JUMP: the command is discarded, no done is issued, and the reset values above apply.

Decomposition:
- Shared package nav_pkg:
  - op encodings;
  - speed encodings;
  - one-hot constants MODE_ZERO/ATTACK/DEFENSE/STEALTH and POS_ZERO/SUBLIGHT/JUMP;
  - status codes;
  - state enum.
- One sub-module, nav_shadow_integrator: a K-bit register with zero/add/load/hold control, driven by the FSM's decoded pos_mode and speed. It keeps the est arithmetic separate from the FSM.

Test Plan:
- Reset then release, no commands → ZERO for 1 cycle (pos_mode=0001), then IDLE with mode=0001, pos_mode=0010, cmd_ready=1, est=0, done never high.
- CRUISE, attack, count=5, ATTACK_SPEED=3 → 5 cycles of mode=0010/pos_mode=0010, est 3,6,9,12,15, then done=1 status=00; est matches integrator output every cycle.
- JUMP to 0x0249, then CRUISE stealth count=2 (STEALTH_SPEED=1) accepted in the done cycle → pos_mode=0100 for 1 cycle, est=0x0249, then est=0x024A, 0x024B.
- JUMP 0xFFFE, CRUISE defense count=3 (speed 1) → est 0xFFFF, 0x0000, 0x0001; no flag asserted.
- CRUISE count=200, abort asserted on the 4th active cycle → est=4×speed, next cycle IDLE with done=1, status=01; CRUISE count=0 → done on t+1, est unchanged; op=11 → done with status=10.
- rst_n dropped mid-CRUISE → outputs take reset values immediately without waiting for clk; no done pulse.
